// File: rtl/program_loader_if.sv
// Program loader bus interface.
// Bundles the serial byte stream (start_i, byte_i, byte_valid_i, byte_ready_o),
// the program-memory write port (wr_en_o, wr_addr_o, wr_data_o) and the
// status outputs (busy_o, done_o, error_o, words_o).
//   slave  : the loader side (drives byte_ready_o, write port and status)
//   master : the host side (drives start_i and the byte stream)
interface program_loader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start_i;
  logic [7:0]            byte_i;
  logic                  byte_valid_i;
  logic                  byte_ready_o;
  logic                  wr_en_o;
  logic [DATA_WIDTH-1:0] wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  logic [15:0]           words_o;

  modport slave (
    input  start_i, byte_i, byte_valid_i,
    output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
           busy_o, done_o, error_o, words_o
  );

  modport master (
    output start_i, byte_i, byte_valid_i,
    input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
           busy_o, done_o, error_o, words_o
  );
endinterface

// File: rtl/program_loader.sv
// Serial program loader.
// Receives a 16-bit little-endian word count followed by that many 32-bit
// little-endian instruction words over a valid/ready byte stream, and writes
// each assembled word to program memory at BASE_ADDRESS + 4*index.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high reset
//   bus   : program_loader_if.slave (byte stream in, memory write port and
//           status out)
module program_loader #(
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(32'h0040_0000)
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           length_q, length_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           asm_q, asm_d;      // bytes 0..2 of the word in flight
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [15:0]           words_q, words_d;  // also the index of the next word

  logic        byte_ready;
  logic        busy;
  logic        xfer;
  logic [15:0] len_new;

  assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA);
  assign busy       = byte_ready;
  assign xfer       = byte_ready && bus.byte_valid_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      length_q   <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      words_q    <= words_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    error_d    = error_q;
    words_d    = words_q;
    len_new    = {bus.byte_i, length_q[7:0]};

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start_i) begin
          state_d    = S_LEN_LO;
          length_d   = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          words_d    = '0;
        end
      end

      S_LEN_LO: begin
        if (xfer) begin
          length_d = {8'h00, bus.byte_i};
          state_d  = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (xfer) begin
          length_d = len_new;
          if ((len_new == 16'd0) || (32'(len_new) > MEMORY_DEPTH)) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte completes the word; the write is registered so it
            // appears in the following cycle while the stream keeps flowing.
            wr_en_d    = 1'b1;
            wr_data_d  = DATA_WIDTH'({bus.byte_i, asm_q});
            wr_addr_d  = BASE_ADDRESS + (DATA_WIDTH'(words_q) << 2);
            words_d    = words_q + 16'd1;
            byte_cnt_d = '0;
            asm_d      = '0;
            if ((words_q + 16'd1) == length_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_i;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byte_ready_o = byte_ready;
  assign bus.busy_o       = busy;
  assign bus.wr_en_o      = wr_en_q;
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.done_o       = done_q;
  assign bus.error_o      = error_q;
  assign bus.words_o      = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: table of header/length vectors with random
// payloads and gaps, hand-written corner sequences, and a write-port monitor
// comparing every write against a byte-queue reference model.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef struct {
    logic [15:0]  len;
    bit           exp_err;
    bit           exp_done;
    logic [15:0]  exp_words;
    int unsigned  max_gap;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   mon_en;
  wr_t  exp_q[$];
  logic [31:0] last_addr;
  logic [31:0] last_data;

  program_loader_if #(.DATA_WIDTH(32)) lif ();

  program_loader #(
    .MEMORY_DEPTH(64),
    .DATA_WIDTH  (32),
    .BASE_ADDRESS(32'h0040_0000)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (lif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (lif.wr_en_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h:%h required=no_write",
                   lif.wr_addr_o, lif.wr_data_o);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", lif.wr_addr_o, e.addr);
          check("wr_data", lif.wr_data_o, e.data);
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        check("wr_en_known", 32'(lif.wr_en_o), 32'd0);
        check("hold_addr", lif.wr_addr_o, last_addr);
        check("hold_data", lif.wr_data_o, last_data);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_addr = '0;
    last_data = '0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(lif.byte_ready_o), 32'd0);
    check({tag, "_wr_en"}, 32'(lif.wr_en_o), 32'd0);
    check({tag, "_wr_addr"}, lif.wr_addr_o, 32'd0);
    check({tag, "_wr_data"}, lif.wr_data_o, 32'd0);
    check({tag, "_busy"}, 32'(lif.busy_o), 32'd0);
    check({tag, "_done"}, 32'(lif.done_o), 32'd0);
    check({tag, "_error"}, 32'(lif.error_o), 32'd0);
    check({tag, "_words"}, 32'(lif.words_o), 32'd0);
  endtask

  task automatic do_start();
    lif.start_i = 1'b1;
    @(posedge clk);
    #1;
    lif.start_i = 1'b0;
    check("busy_after_start", 32'(lif.busy_o), 32'd1);
    check("done_cleared", 32'(lif.done_o), 32'd0);
    check("error_cleared", 32'(lif.error_o), 32'd0);
    check("words_cleared", 32'(lif.words_o), 32'd0);
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
    int unsigned gap;
    int unsigned waited;
    gap = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
    if (gap != 0) begin
      lif.byte_valid_i = 1'b0;
      lif.byte_i       = 8'($urandom);
      repeat (gap) @(posedge clk);
      #1;
    end
    lif.byte_i       = b;
    lif.byte_valid_i = 1'b1;
    waited = 0;
    while (lif.byte_ready_o !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (lif.byte_ready_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=%b required=1", lif.byte_ready_o);
      lif.byte_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    lif.byte_valid_i = 1'b0;
  endtask

  task automatic run_load(input logic [15:0] len, input bq_t data, input bit push_exp,
                          input int unsigned max_gap, input bit pulse_start);
    logic [31:0] word;
    do_start();
    send_byte(len[7:0], max_gap);
    send_byte(len[15:8], max_gap);
    word = '0;
    for (int i = 0; i < data.size(); i++) begin
      word[8*(i%4) +: 8] = data[i];
      if (pulse_start && i == 4) lif.start_i = 1'b1;
      send_byte(data[i], max_gap);
      lif.start_i = 1'b0;
      if (push_exp && (i % 4) == 3)
        exp_q.push_back('{addr: BASE + 32'(i / 4) * 32'd4, data: word});
    end
  endtask

  task automatic post_check(input string tag, input logic [15:0] len, input bit exp_err,
                            input logic [15:0] exp_words);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_error"}, 32'(lif.error_o), 32'(exp_err));
    check({tag, "_done"}, 32'(lif.done_o), 32'(!exp_err));
    check({tag, "_words"}, 32'(lif.words_o), 32'(exp_words));
    check({tag, "_ready"}, 32'(lif.byte_ready_o), 32'd0);
    check({tag, "_busy"}, 32'(lif.busy_o), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    if (!exp_err)
      check({tag, "_last_addr"}, lif.wr_addr_o, BASE + 32'(len - 16'd1) * 32'd4);
  endtask

  task automatic offer_after_end(input logic [15:0] exp_words);
    lif.byte_i       = 8'($urandom);
    lif.byte_valid_i = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("ready_after_end", 32'(lif.byte_ready_o), 32'd0);
    end
    lif.byte_valid_i = 1'b0;
    check("words_after_end", 32'(lif.words_o), 32'(exp_words));
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    vec_t vecs[9];
    bq_t  d;

    vecs[0] = '{16'd0,      1'b1, 1'b0, 16'd0,  1};
    vecs[1] = '{16'd65,     1'b1, 1'b0, 16'd0,  2};
    vecs[2] = '{16'hFFFF,   1'b1, 1'b0, 16'd0,  0};
    vecs[3] = '{16'h0140,   1'b1, 1'b0, 16'd0,  1};
    vecs[4] = '{16'd1,      1'b0, 1'b1, 16'd1,  2};
    vecs[5] = '{16'd2,      1'b0, 1'b1, 16'd2,  0};
    vecs[6] = '{16'd64,     1'b0, 1'b1, 16'd64, 3};
    vecs[7] = '{16'd63,     1'b0, 1'b1, 16'd63, 1};
    vecs[8] = '{16'd5,      1'b0, 1'b1, 16'd5,  0};

    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    last_addr = '0;
    last_data = '0;
    lif.start_i      = 1'b0;
    lif.byte_i       = '0;
    lif.byte_valid_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");
    mon_en = 1'b1;

    // Basic two-word load with fixed expectations.
    exp_q.push_back('{addr: 32'h0040_0000, data: 32'h0000_0013});
    exp_q.push_back('{addr: 32'h0040_0004, data: 32'h0010_0093});
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(16'd2, d, 1'b0, 0, 1'b0);
    post_check("basic", 16'd2, 1'b0, 16'd2);
    offer_after_end(16'd2);

    // Header/length table with random payloads and gaps.
    foreach (vecs[v]) begin
      d = vecs[v].exp_err ? rand_bytes(0) : rand_bytes(4 * int'(vecs[v].len));
      run_load(vecs[v].len, d, 1'b1, vecs[v].max_gap, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("vec_error", 32'(lif.error_o), 32'(vecs[v].exp_err));
      check("vec_done", 32'(lif.done_o), 32'(vecs[v].exp_done));
      check("vec_words", 32'(lif.words_o), 32'(vecs[v].exp_words));
      check("vec_ready", 32'(lif.byte_ready_o), 32'd0);
      check("vec_pending", 32'(exp_q.size()), 32'd0);
      if (vecs[v].exp_done)
        check("vec_last_addr", lif.wr_addr_o, BASE + 32'(vecs[v].len - 16'd1) * 32'd4);
      offer_after_end(vecs[v].exp_words);
    end

    // Reset after the second data byte of a one-word load.
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    do_reset();
    check_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    check("midreset_idle_busy", 32'(lif.busy_o), 32'd0);
    d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_q.push_back('{addr: 32'h0040_0000, data: 32'hDEAD_BEEF});
    run_load(16'd1, d, 1'b0, 1, 1'b0);
    post_check("after_reset", 16'd1, 1'b0, 16'd1);

    // Back-to-back bytes across word boundaries with start_i pulsed mid-load.
    d = rand_bytes(12);
    run_load(16'd3, d, 1'b1, 0, 1'b1);
    post_check("b2b_start", 16'd3, 1'b0, 16'd3);

    // Randomized loads.
    for (int r = 0; r < 8; r++) begin
      int unsigned n;
      n = $urandom_range(12, 1);
      d = rand_bytes(4 * int'(n));
      run_load(16'(n), d, 1'b1, $urandom_range(2, 0), r[0]);
      post_check("rand", 16'(n), 1'b0, 16'(n));
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
